// File: rtl/mem_access_stage.sv
// Memory stage: turns EX loads/stores into req/ack data-memory transactions,
// formats load results for MEM/WB and stalls the pipeline while one is in flight.
`ifndef MEM_ACCESS_STAGE_DEFS
`define MEM_ACCESS_STAGE_DEFS
`define RegBus      31:0
`define RegAddrBus  4:0
`define AluOpBus    7:0
`define EX_LB_OP    8'hE0
`define EX_LH_OP    8'hE1
`define EX_LW_OP    8'hE2
`define EX_LBU_OP   8'hE3
`define EX_LHU_OP   8'hE4
`define EX_SB_OP    8'hE8
`define EX_SH_OP    8'hE9
`define EX_SW_OP    8'hEA
`endif

module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               w_enable_i,
  input  logic [`RegAddrBus] w_addr_i,
  input  logic [`RegBus]     w_data_i,
  input  logic [`AluOpBus]   aluop_i,
  input  logic [`RegBus]     mem_addr_i,
  output logic               w_enable_o,
  output logic [`RegAddrBus] w_addr_o,
  output logic [`RegBus]     w_data_o,
  output logic               stall_req_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [`RegBus]     mem_addr_o,
  output logic [3:0]         mem_be_o,
  output logic [`RegBus]     mem_wdata_o,
  input  logic [`RegBus]     mem_rdata_i,
  input  logic               mem_ack_i,
  output logic               mem_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  localparam logic [CNT_W-1:0] L_TMO    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] L_TMO_M1 = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [`RegBus]     r_addr;
  logic [`RegBus]     r_wdata;
  logic [`RegBus]     r_rdata;
  logic [3:0]         r_be;
  logic               r_we;
  logic [`AluOpBus]   r_op;
  logic [1:0]         r_off;
  logic [`RegAddrBus] r_waddr;
  logic               r_wen;
  logic               r_timeout;

  logic               w_isLoad;
  logic               w_isStore;
  logic               w_aligned;
  logic [3:0]         w_be;
  logic [`RegBus]     w_wdata;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [`RegBus]     w_loadData;

  always_comb begin
    w_isLoad  = 1'b0;
    w_isStore = 1'b0;
    w_aligned = 1'b1;
    w_be      = 4'b1111;
    w_wdata   = '0;
    case (aluop_i)
      `EX_LB_OP, `EX_LBU_OP: w_isLoad = 1'b1;
      `EX_LH_OP, `EX_LHU_OP: begin
        w_isLoad  = 1'b1;
        w_aligned = ~mem_addr_i[0];
      end
      `EX_LW_OP: begin
        w_isLoad  = 1'b1;
        w_aligned = (mem_addr_i[1:0] == 2'b00);
      end
      `EX_SB_OP: begin
        w_isStore = 1'b1;
        w_be      = 4'b0001 << mem_addr_i[1:0];
        w_wdata   = {4{w_data_i[7:0]}};
      end
      `EX_SH_OP: begin
        w_isStore = 1'b1;
        w_aligned = ~mem_addr_i[0];
        w_be      = mem_addr_i[1] ? 4'b1100 : 4'b0011;
        w_wdata   = {2{w_data_i[15:0]}};
      end
      `EX_SW_OP: begin
        w_isStore = 1'b1;
        w_aligned = (mem_addr_i[1:0] == 2'b00);
        w_wdata   = w_data_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (r_off)
      2'd0:    w_byte = r_rdata[7:0];
      2'd1:    w_byte = r_rdata[15:8];
      2'd2:    w_byte = r_rdata[23:16];
      default: w_byte = r_rdata[31:24];
    endcase
    w_half = r_off[1] ? r_rdata[31:16] : r_rdata[15:0];
    case (r_op)
      `EX_LB_OP:  w_loadData = {{24{w_byte[7]}}, w_byte};
      `EX_LBU_OP: w_loadData = {24'b0, w_byte};
      `EX_LH_OP:  w_loadData = {{16{w_half[15]}}, w_half};
      `EX_LHU_OP: w_loadData = {16'b0, w_half};
      default:    w_loadData = r_rdata;
    endcase
  end

  // DONE always falls back to IDLE so the instruction still held upstream cannot re-issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_be      <= '0;
      r_we      <= 1'b0;
      r_op      <= '0;
      r_off     <= '0;
      r_waddr   <= '0;
      r_wen     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if ((w_isLoad || w_isStore) && w_aligned) begin
            r_state   <= S_REQ;
            r_cnt     <= '0;
            r_addr    <= {mem_addr_i[31:2], 2'b00};
            r_be      <= w_be;
            r_wdata   <= w_wdata;
            r_we      <= w_isStore;
            r_op      <= aluop_i;
            r_off     <= mem_addr_i[1:0];
            r_waddr   <= w_addr_i;
            r_wen     <= w_enable_i;
            r_timeout <= 1'b0;
          end
        end
        S_REQ: begin
          if (mem_ack_i) begin
            r_rdata <= mem_rdata_i;
            r_state <= S_DONE;
          end else begin
            if (r_cnt != L_TMO) r_cnt <= r_cnt + 1'b1;
            if (r_cnt == L_TMO_M1) begin
              r_state   <= S_DONE;
              r_timeout <= 1'b1;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_enable_o  = 1'b0;
    w_addr_o    = '0;
    w_data_o    = '0;
    stall_req_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    mem_err_o   = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          if (!(w_isLoad || w_isStore)) begin
            w_enable_o = w_enable_i;
            w_addr_o   = w_addr_i;
            w_data_o   = w_data_i;
          end else if (!w_aligned) begin
            mem_err_o = 1'b1;
          end else begin
            stall_req_o = 1'b1;
          end
        end
        S_REQ: begin
          stall_req_o = 1'b1;
          mem_req_o   = 1'b1;
          mem_we_o    = r_we;
          mem_addr_o  = r_addr;
          mem_be_o    = r_be;
          mem_wdata_o = r_wdata;
        end
        S_DONE: begin
          w_addr_o  = r_waddr;
          mem_err_o = r_timeout;
          if (!r_we && !r_timeout) begin
            w_enable_o = r_wen && (r_waddr != '0);
            w_data_o   = w_loadData;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage directly downstream of the execute stage.
- Consumes the execute stage's writeback triple (w_enable, w_addr, w_data), aluop and effective address mem_addr, and performs loads and stores over a req/ack data-memory port.
- Formats load data (byte/half select, sign/zero extension) and forwards the result to the MEM/WB register.
- Stalls the pipeline while a memory transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: maximum REQ-state cycles without mem_ack_i before the access aborts with an error.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- w_enable_i  in  1  write enable from EX
- w_addr_i  in  `RegAddrBus  destination register from EX
- w_data_i  in  `RegBus  ALU result, or store data for stores
- aluop_i  in  `AluOpBus  operation from EX
- mem_addr_i  in  `RegBus  effective address (r1 + offset)
- w_enable_o  out  1  write enable to MEM/WB
- w_addr_o  out  `RegAddrBus  destination register to MEM/WB
- w_data_o  out  `RegBus  writeback data to MEM/WB
- stall_req_o  out  1  pipeline stall request
- mem_req_o  out  1  data-memory request
- mem_we_o  out  1  1 = store, 0 = load
- mem_addr_o  out  `RegBus  word-aligned address {addr[31:2],2'b00}
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  `RegBus  store data, lane-replicated
- mem_rdata_i  in  `RegBus  load data, valid while mem_ack_i is high
- mem_ack_i  in  1  transaction complete
- mem_err_o  out  1  one-cycle pulse on misaligned access or timeout

Behaviour:
- Memory ops are EX_LB/LH/LW/LBU/LHU_OP and EX_SB/SH/SW_OP. Every other aluop is a pass-through: outputs equal inputs combinationally, no stall.
- FSM states:
  - IDLE → REQ: on a memory op with an aligned address. stall_req_o is high combinationally in that same IDLE cycle. Request registers (addr, be, wdata, we, op, byte offset, w_addr) are captured on entry to REQ.
  - REQ: mem_req_o = 1 and stall_req_o = 1. mem_addr/be/wdata/we are driven from the captured registers and stay stable until ack. mem_ack_i is sampled only in REQ.
  - REQ → DONE: on ack. rdata is captured on the ack edge.
  - REQ → DONE on timeout: when the counter reaches TIMEOUT_CYCLES with no ack. mem_err_o pulses in the DONE cycle.
  - DONE: stall_req_o = 0, mem_req_o = 0. Outputs present the result for exactly one cycle; the upstream register advances at the end of this cycle. DONE → IDLE unconditionally, so the same held instruction never re-triggers.
- Latency: a load or store with ack in the first REQ cycle takes 3 cycles (IDLE, REQ, DONE); each extra wait cycle adds one.
- Alignment rules:
  - LH/LHU/SH require addr[0] = 0.
  - LW/SW require addr[1:0] = 0.
  - Byte ops are always aligned.
  - On a misaligned access: no request, no stall, mem_err_o = 1 for that cycle, w_enable_o = 0, FSM stays in IDLE.
- Store formatting:
  - SB: wdata = {4{data[7:0]}}, be = 4'b0001 << addr[1:0].
  - SH: wdata = {2{data[15:0]}}, be = addr[1] ? 4'b1100 : 4'b0011.
  - SW: wdata = data, be = 4'b1111.
  - Stores always force w_enable_o = 0.
- Load formatting (in DONE):
  - LB/LBU select byte addr[1:0]; LH/LHU select half addr[1]; LW takes the full word.
  - Sign-extend for LB/LH, zero-extend for LBU/LHU.
  - w_enable_o = captured enable, except 0 if the destination is x0.
  - On timeout: w_enable_o = 0 and w_data_o = 0.
- Loads force mem_be_o = 4'b1111 and mem_we_o = 0.
- Outputs outside REQ: mem_req_o = 0, mem_be_o = 0, mem_wdata_o = 0, mem_addr_o = 0.
- Reset: state IDLE, counter 0, captured registers 0. While rst is high, all outputs are 0. Reset asserted in REQ drops mem_req_o on the next cycle; a late ack arriving in IDLE is ignored.
- The timeout counter clears on entry to REQ and saturates at TIMEOUT_CYCLES.

Test Plan:
- SW: mem_addr_i = 0x100, w_data_i = 0xDEADBEEF, ack in the first REQ cycle → one cycle with mem_req_o = 1, mem_we_o = 1, mem_be_o = 4'hF, mem_wdata_o = 0xDEADBEEF, mem_addr_o = 0x100; stall high for 2 cycles; w_enable_o = 0.
- LB at 0x103, rdata = 0x80FF_0000, rd = 5 → DONE: w_data_o = 0xFFFFFF80, w_addr_o = 5, w_enable_o = 1. The same access as LBU → 0x00000080.
- SH at 0x102, data = 0x1234ABCD, ack after 3 wait cycles → mem_be_o = 4'b1100, mem_wdata_o = 0xABCDABCD held stable for 4 REQ cycles; stall high for 5 cycles.
- LW at 0x101 → no mem_req_o, mem_err_o pulse, w_enable_o = 0, stall_req_o = 0. An ADD with w_data_i = 7 on the next cycle passes through unchanged.
- TIMEOUT_CYCLES = 4 with no ack → 4 REQ cycles, then DONE with mem_err_o = 1, w_enable_o = 0; FSM returns to IDLE.
- rst asserted during the second REQ cycle → mem_req_o = 0 and stall_req_o = 0 next cycle; an ack asserted the following cycle produces no output change.
